instr_fetch: RTL and testbench

- Instruction fetch unit for the 8-bit CPU. It is the reader side of the ROM interface.
- Drives the ROM address from an internal program counter and captures the returned bytes.
- Assembles 1- or 2-byte instructions and hands them to the decoder over a valid/ready handshake.
- Supports jumps: a new PC is loaded from the execute stage and any in-flight fetch is aborted.

---
 rtl/cpu_if_pkg.sv | 18 +
 rtl/instr_fetch.sv | 95 +++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_if_pkg.sv
// rtl/cpu_if_pkg.sv - shared fetch/decode types, constants and helpers
package cpu_if_pkg;

  localparam int TWO_BYTE_BIT = 7;

  typedef enum logic [2:0] {
    S_OP_ADDR,
    S_OP_DATA,
    S_ARG_ADDR,
    S_ARG_DATA,
    S_VALID
  } fetch_state_t;

  function automatic logic is_two_byte(input logic [7:0] opcode);
    return opcode[TWO_BYTE_BIT];
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC + fetch FSM reading a latency-1 ROM and presenting 1/2-byte instructions
module instr_fetch
  import cpu_if_pkg::*;
#(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter int         TWO_BYTE_BIT = cpu_if_pkg::TWO_BYTE_BIT
) (
  input  logic       clk_IF,
  input  logic       rstn_IF,
  input  logic       fetch_en_IF,
  output logic [7:0] addr_ROM_IF,
  input  logic [7:0] data_ROM_IF,
  input  logic       jump_en_IF,
  input  logic [7:0] jump_addr_IF,
  output logic       instr_valid_IF,
  input  logic       instr_ready_IF,
  output logic [7:0] opcode_IF,
  output logic [7:0] operand_IF,
  output logic       two_byte_IF,
  output logic [7:0] instr_pc_IF
);

  fetch_state_t state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [7:0]   instr_pc_q, instr_pc_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [7:0]   operand_q, operand_d;

  always_ff @(posedge clk_IF or negedge rstn_IF) begin
    if (!rstn_IF) begin
      state_q    <= S_OP_ADDR;
      pc_q       <= RESET_VECTOR;
      instr_pc_q <= 8'h00;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
    end
  end

  // A jump overrides every state, including a handshake in S_VALID.
  always_comb begin
    state_d = state_q;
    if (jump_en_IF) begin
      state_d = S_OP_ADDR;
    end else begin
      unique case (state_q)
        S_OP_ADDR:  if (fetch_en_IF) state_d = S_OP_DATA;
        S_OP_DATA:  state_d = data_ROM_IF[TWO_BYTE_BIT] ? S_ARG_ADDR : S_VALID;
        S_ARG_ADDR: state_d = S_ARG_DATA;
        S_ARG_DATA: state_d = S_VALID;
        S_VALID:    if (instr_ready_IF) state_d = S_OP_ADDR;
        default:    state_d = S_OP_ADDR;
      endcase
    end
  end

  always_comb begin
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    if (jump_en_IF) begin
      pc_d = jump_addr_IF;
    end else begin
      unique case (state_q)
        S_OP_ADDR: if (fetch_en_IF) instr_pc_d = pc_q;
        S_OP_DATA: begin
          opcode_d = data_ROM_IF;
          pc_d     = pc_q + 8'd1;
          if (!data_ROM_IF[TWO_BYTE_BIT]) operand_d = 8'h00;
        end
        S_ARG_DATA: begin
          operand_d = data_ROM_IF;
          pc_d      = pc_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    instr_valid_IF = (state_q == S_VALID);
    addr_ROM_IF    = pc_q;
    opcode_IF      = opcode_q;
    operand_IF     = operand_q;
    two_byte_IF    = opcode_q[TWO_BYTE_BIT];
    instr_pc_IF    = instr_pc_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a latency-1 ROM model
module tb_instr_fetch;

  typedef struct {
    logic [7:0] op;
    logic [7:0] arg;
    logic       two;
    logic [7:0] pc;
    int         lat;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic       fetch_en;
  logic [7:0] addr;
  logic [7:0] rom_q;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       valid;
  logic       ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       two_byte;
  logic [7:0] instr_pc;

  logic [7:0] mem [256];
  exp_t       exp_q [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         hs_count = 0;
  int         ref_cyc = 0;
  logic       vprev = 1'b0;
  logic       rprev = 1'b0;

  instr_fetch #(.RESET_VECTOR(8'h00), .TWO_BYTE_BIT(7)) dut (
    .clk_IF        (clk),
    .rstn_IF       (rstn),
    .fetch_en_IF   (fetch_en),
    .addr_ROM_IF   (addr),
    .data_ROM_IF   (rom_q),
    .jump_en_IF    (jump_en),
    .jump_addr_IF  (jump_addr),
    .instr_valid_IF(valid),
    .instr_ready_IF(ready),
    .opcode_IF     (opcode),
    .operand_IF    (operand),
    .two_byte_IF   (two_byte),
    .instr_pc_IF   (instr_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0]     = 8'h12;
    mem[1]     = 8'h85;
    mem[2]     = 8'h3C;
    mem[3]     = 8'h07;
    mem[8'hFF] = 8'h90;
  end

  always @(posedge clk) begin
    rom_q <= mem[addr];
    cyc   <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] pc,
                          input int lat);
    exp_t e;
    e.op  = op;
    e.arg = arg;
    e.two = op[7];
    e.pc  = pc;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Latency is measured from reset release or from the previous handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      vprev = 1'b0;
    end else begin
      if (!rprev) ref_cyc = cyc;
      if (valid && !vprev && exp_q.size() > 0 && exp_q[0].lat != 0)
        check_val("valid_latency", cyc - ref_cyc, exp_q[0].lat);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_handshake", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("opcode", opcode, e.op);
          check_val("operand", operand, e.arg);
          check_val("two_byte", two_byte, e.two);
          check_val("instr_pc", instr_pc, e.pc);
        end
        hs_count++;
        ref_cyc = cyc;
      end
      vprev = valid;
    end
    rprev = rstn;
  end

  task automatic wait_hs(input int n, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      if (hs_count >= n) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; fetch_en = 1'b0; ready = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
    push_exp(8'h12, 8'h00, 8'h00, 2);
    push_exp(8'h85, 8'h3C, 8'h01, 5);
    push_exp(8'h07, 8'h00, 8'h03, 3);

    repeat (2) @(negedge clk);
    check_val("rst_valid", valid, 1'b0);
    check_val("rst_opcode", opcode, 8'h00);
    check_val("rst_operand", operand, 8'h00);
    check_val("rst_two_byte", two_byte, 1'b0);
    check_val("rst_instr_pc", instr_pc, 8'h00);
    check_val("rst_addr", addr, 8'h00);

    @(posedge clk); #1;
    rstn = 1'b1; fetch_en = 1'b1; ready = 1'b1;

    wait_hs(1, "timeout_hs1");
    #1 ready = 1'b0;

    wait_valid("timeout_valid_85");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check_val("stall_valid", valid, 1'b1);
      check_val("stall_opcode", opcode, 8'h85);
      check_val("stall_operand", operand, 8'h3C);
      check_val("stall_addr", addr, 8'h03);
    end
    check_val("stall_hs_count", hs_count, 1);
    @(posedge clk); #1 ready = 1'b1;

    wait_hs(3, "timeout_hs3");
    #1 fetch_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("fetch_off_addr", addr, 8'h04);
    check_val("fetch_off_valid", valid, 1'b0);

    @(posedge clk); #1;
    jump_en = 1'b1; jump_addr = 8'h01;
    @(posedge clk); #1;
    jump_en = 1'b0; fetch_en = 1'b1;
    @(negedge clk);
    check_val("jump1_addr", addr, 8'h01);

    // Two edges later the 2-byte opcode 85 is in S_ARG_ADDR; abort it.
    @(posedge clk);
    @(posedge clk); #1;
    jump_en = 1'b1; jump_addr = 8'hFF; ready = 1'b0;
    push_exp(8'h90, 8'h12, 8'hFF, 0);
    @(posedge clk); #1 jump_en = 1'b0;
    @(negedge clk);
    check_val("abort_addr", addr, 8'hFF);
    check_val("abort_valid", valid, 1'b0);

    wait_valid("timeout_valid_90");
    check_val("abort_hs_count", hs_count, 3);
    @(posedge clk); #1;
    ready = 1'b1; jump_en = 1'b1; jump_addr = 8'h02;
    push_exp(8'h3C, 8'h00, 8'h02, 0);
    @(posedge clk); #1 jump_en = 1'b0;
    @(negedge clk);
    check_val("jump_hs_addr", addr, 8'h02);
    check_val("jump_hs_valid", valid, 1'b0);
    check_val("jump_hs_count", hs_count, 4);

    wait_hs(5, "timeout_hs5");
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    check_val("async_rst_valid", valid, 1'b0);
    check_val("async_rst_opcode", opcode, 8'h00);
    check_val("async_rst_two_byte", two_byte, 1'b0);
    check_val("async_rst_instr_pc", instr_pc, 8'h00);
    check_val("async_rst_addr", addr, 8'h00);

    @(posedge clk); #1;
    push_exp(8'h12, 8'h00, 8'h00, 2);
    rstn = 1'b1;
    wait_hs(6, "timeout_hs6");

    repeat (2) @(negedge clk);
    check_val("queue_empty", exp_q.size(), 0);
    check_val("total_handshakes", hs_count, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
